// File: rtl/regfile_mp_pkg.sv
// ============================================================================
// regfile_mp_pkg : shared defaults and clear-FSM encodings for regfile_mp
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_mp_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_ZERO_R0 = 0;
  localparam int DEF_BYPASS  = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_mp_rdport.sv
// ============================================================================
// regfile_mp_rdport : one registered read port with range check and bypass
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ZERO_R0 = DEF_ZERO_R0,
  parameter int BYPASS  = DEF_BYPASS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              rvalid_d, rvalid_q;

  // Addresses beyond DEPTH match no entry and fall through to zero/invalid.
  always_comb begin
    rdata_d  = '0;
    rvalid_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra == ADDR_W'(i)) begin
        rdata_d  = mem[i];
        rvalid_d = valid[i];
      end
    end
    if (ZERO_R0 != 0 && ra == '0) begin
      rdata_d  = '0;
      rvalid_d = 1'b1;
    end
    // Write enables arrive pre-qualified, so port 1 applied last gives its priority.
    if (BYPASS != 0) begin
      if (we0 && wa0 == ra) begin
        rdata_d  = wd0;
        rvalid_d = 1'b1;
      end
      if (we1 && wa1 == ra) begin
        rdata_d  = wd1;
        rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : 2-write / NUM_RD-read register file with valid bits and clear sweep
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int ZERO_R0 = DEF_ZERO_R0,
  parameter int BYPASS  = DEF_BYPASS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     write1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid,
  input  logic                     clr,
  output logic                     busy
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              we0_ok, we1_ok;

  // A write is real only in IDLE, in range, and not aimed at a hardwired zero.
  assign we0_ok = write0 && (state_q == ST_IDLE) && ({1'b0, wa0} < c_depth)
                  && !(ZERO_R0 != 0 && wa0 == '0);
  assign we1_ok = write1 && (state_q == ST_IDLE) && ({1'b0, wa1} < c_depth)
                  && !(ZERO_R0 != 0 && wa1 == '0);

  assign busy = (state_q == ST_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (we0_ok && wa0 == ADDR_W'(i)) begin
        mem_d[i]   = wd0;
        valid_d[i] = 1'b1;
      end
      if (we1_ok && wa1 == ADDR_W'(i)) begin
        mem_d[i]   = wd1;
        valid_d[i] = 1'b1;
      end
      if (state_q == ST_CLEAR && cnt_q == ADDR_W'(i)) begin
        mem_d[i]   = '0;
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      mem_q   <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0),
      .BYPASS (BYPASS)
    ) u_rdport (
      .clk   (clk),
      .rst   (rst),
      .ra    (ra[k*ADDR_W +: ADDR_W]),
      .mem   (mem_q),
      .valid (valid_q),
      .we0   (we0_ok),
      .wa0   (wa0),
      .wd0   (wd0),
      .we1   (we1_ok),
      .wa1   (wa1),
      .wd1   (wd1),
      .rdata (rdata[k*DATA_W +: DATA_W]),
      .rvalid(rvalid[k])
    );
  end

endmodule

`default_nettype wire
